// File: rtl/cvxif_result_arbiter_if.sv
// Result-channel bundle between the execution units, the arbiter and the core.
// master = arbiter side, slave = units/core side.
interface cvxif_result_arbiter_if #(
  parameter int NumReq    = 4,
  parameter int IdWidth   = 3,
  parameter int DataWidth = 64
);
  logic [NumReq-1:0]           req_valid;
  logic [NumReq-1:0]           req_ready;
  logic [NumReq*IdWidth-1:0]   req_id;
  logic [NumReq*DataWidth-1:0] req_data;
  logic [NumReq*5-1:0]         req_rd;
  logic [NumReq-1:0]           req_we;
  logic                        result_valid;
  logic                        result_ready;
  logic [IdWidth-1:0]          result_id;
  logic [DataWidth-1:0]        result_data;
  logic [4:0]                  result_rd;
  logic                        result_we;

  modport master (
    input  req_valid, req_id, req_data, req_rd, req_we, result_ready,
    output req_ready, result_valid, result_id, result_data, result_rd,
    output result_we
  );

  modport slave (
    output req_valid, req_id, req_data, req_rd, req_we, result_ready,
    input  req_ready, result_valid, result_id, result_data, result_rd,
    input  result_we
  );
endinterface

// File: rtl/cvxif_result_arbiter.sv
// Round-robin arbiter for the CV-X-IF result channel with commit/kill scoreboard.
// Optional stall counter enabled by defining CVXIF_ARB_PERF_EN.
module cvxif_result_arbiter #(
  parameter int NumReq    = 4,
  parameter int IdWidth   = 3,
  parameter int DataWidth = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  cvxif_result_arbiter_if.master bus,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               drop_o,
  output logic [31:0]        perf_stall_o
);
  localparam int NumIds = 2 ** IdWidth;
  localparam int PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [NumIds-1:0]    committed_q, committed_d;
  logic [NumIds-1:0]    killed_q, killed_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic                 valid_q;
  logic                 we_q;
  logic [IdWidth-1:0]   id_q;
  logic [DataWidth-1:0] data_q;
  logic [4:0]           rd_q;

  logic [IdWidth-1:0]   id_w [NumReq];
  logic [NumReq-1:0]    elig;
  logic [NumReq-1:0]    drop;
  logic [PtrW-1:0]      idx;
  logic [PtrW-1:0]      win;
  logic                 found;
  logic                 grant;
  logic                 hs;

  // Per-unit id unpack, eligibility and kill detection
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      id_w[i] = bus.req_id[i*IdWidth +: IdWidth];
      elig[i] = bus.req_valid[i] & committed_q[id_w[i]]
              & ~killed_q[id_w[i]];
      drop[i] = bus.req_valid[i] & killed_q[id_w[i]] & ~rst_i;
    end
  end

  // Round-robin search starting at the pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx = PtrW'((int'(ptr_q) + k) % NumReq);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign hs    = valid_q & bus.result_ready;
  assign grant = found & (~valid_q | bus.result_ready) & ~rst_i;

  // Consume handshake: grant winner, drop killed results
  always_comb begin
    bus.req_ready = drop;
    if (grant) bus.req_ready[win] = 1'b1;
  end

  assign drop_o = |drop;

  // Scoreboard next state; commit/kill set wins over a same-id clear
  always_comb begin
    committed_d = committed_q;
    killed_d    = killed_q;
    if (hs) begin
      committed_d[id_q] = 1'b0;
      killed_d[id_q]    = 1'b0;
    end
    for (int i = 0; i < NumReq; i++) begin
      if (drop[i]) begin
        committed_d[id_w[i]] = 1'b0;
        killed_d[id_w[i]]    = 1'b0;
      end
    end
    if (commit_valid_i) begin
      if (commit_kill_i) killed_d[commit_id_i] = 1'b1;
      else               committed_d[commit_id_i] = 1'b1;
    end
  end

  // Pointer moves past the granted unit only
  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (win == PtrW'(NumReq - 1)) ? '0 : win + 1'b1;
    end
  end

  // Scoreboard, pointer and output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      committed_q <= '0;
      killed_q    <= '0;
      ptr_q       <= '0;
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      id_q        <= '0;
      data_q      <= '0;
      rd_q        <= '0;
    end else begin
      committed_q <= committed_d;
      killed_q    <= killed_d;
      ptr_q       <= ptr_d;
      if (grant) begin
        valid_q <= 1'b1;
        we_q    <= bus.req_we[win];
        id_q    <= id_w[win];
        data_q  <= bus.req_data[win*DataWidth +: DataWidth];
        rd_q    <= bus.req_rd[win*5 +: 5];
      end else if (hs) begin
        valid_q <= 1'b0;
        we_q    <= 1'b0;
      end
    end
  end

  assign bus.result_valid = valid_q;
  assign bus.result_we    = we_q;
  assign bus.result_id    = id_q;
  assign bus.result_data  = data_q;
  assign bus.result_rd    = rd_q;

`ifdef CVXIF_ARB_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of backpressured cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (valid_q && !bus.result_ready && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall_o = stall_q;
`else
  assign perf_stall_o = '0;
`endif

  // Two pending requesters must never carry the same id
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NumReq; i++) begin
        for (int j = i + 1; j < NumReq; j++) begin
          assert (!(bus.req_valid[i] && bus.req_valid[j]
                    && id_w[i] == id_w[j]));
        end
      end
    end
  end
endmodule

// File: tb/tb_cvxif_result_arbiter.sv
// Bench for cvxif_result_arbiter: directed vectors, corner sequences,
// and randomized traffic against a transaction-level model.
module tb_cvxif_result_arbiter;
  localparam int N  = 4;
  localparam int IW = 3;
  localparam int DW = 64;
`ifdef CVXIF_ARB_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cv;
  logic          ck;
  logic [IW-1:0] cid;
  logic          drop;
  logic [31:0]   perf;

  always #5 clk = ~clk;

  cvxif_result_arbiter_if #(.NumReq(N), .IdWidth(IW), .DataWidth(DW)) bus ();

  cvxif_result_arbiter #(.NumReq(N), .IdWidth(IW), .DataWidth(DW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus),
    .commit_valid_i(cv),
    .commit_id_i(cid),
    .commit_kill_i(ck),
    .drop_o(drop),
    .perf_stall_o(perf)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit        r;
    bit        c;
    bit [2:0]  cid;
    bit        k;
    bit [3:0]  v;
    bit [11:0] ids;
    bit        rr;
    bit [3:0]  e_rdy;
    bit        e_drop;
    bit        e_val;
    bit [2:0]  e_id;
    bit [63:0] e_data;
    bit [4:0]  e_rd;
  } vec_t;

  vec_t tv [21];

  function automatic vec_t mk(bit r, bit c, bit [2:0] id, bit k, bit [3:0] v,
                              bit [11:0] ids, bit rr, bit [3:0] er, bit ed,
                              bit ev, bit [2:0] eid, bit [63:0] edat,
                              bit [4:0] erd);
    vec_t t;
    t = '{r, c, id, k, v, ids, rr, er, ed, ev, eid, edat, erd};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cv = 1'b0;
    ck = 1'b0;
    cid = '0;
    bus.req_valid = '0;
    bus.result_ready = 1'b0;
  endtask

  task automatic fixed_data();
    for (int u = 0; u < N; u++) begin
      bus.req_data[u*DW +: DW] = 64'h14 + 64'(u);
      bus.req_rd[u*5 +: 5] = 5'(4 + u);
    end
    bus.req_we = '1;
    bus.req_id = '0;
  endtask

  task automatic set_req(input int u, input bit v, input logic [IW-1:0] id);
    bus.req_valid[u] = v;
    bus.req_id[u*IW +: IW] = id;
  endtask

  task automatic commit(input logic [IW-1:0] id, input bit kill);
    cv = 1'b1;
    cid = id;
    ck = kill;
  endtask

  task automatic chk_out(input string nm, input bit v, input logic [2:0] id,
                         input logic [63:0] d, input logic [4:0] rd);
    chk({nm, "_valid"}, bus.result_valid, v);
    chk({nm, "_we"}, bus.result_we, v);
    if (v) begin
      chk({nm, "_id"}, bus.result_id, id);
      chk({nm, "_data"}, bus.result_data, d);
      chk({nm, "_rd"}, bus.result_rd, rd);
    end
  endtask

  // Transaction-level reference model state
  bit          m_com [8];
  bit          m_kil [8];
  bit          m_has;
  logic [2:0]  m_id;
  logic [63:0] m_data;
  logic [4:0]  m_rd;
  bit          m_we;
  int          m_ptr;
  logic [31:0] m_stall;

  bit          rv   [N];
  logic [2:0]  rid  [N];
  logic [63:0] rdat [N];
  logic [4:0]  rrd  [N];
  bit          rwe  [N];

  initial begin
    rst = 1'b1;
    idle();
    fixed_data();

    tv[0]  = mk(0,0,0,0,4'b0000,12'h000,0, 4'b0000,0,0,0,0,0);
    tv[1]  = mk(0,1,2,0,4'b0000,12'h000,0, 4'b0000,0,0,0,0,0);
    tv[2]  = mk(0,0,0,0,4'b0010,12'h010,0, 4'b0010,0,0,0,0,0);
    tv[3]  = mk(0,0,0,0,4'b0000,12'h000,1, 4'b0000,0,1,2,64'h15,5);
    tv[4]  = mk(0,0,0,0,4'b0000,12'h000,1, 4'b0000,0,0,0,0,0);
    tv[5]  = mk(0,0,0,0,4'b0100,12'h100,0, 4'b0000,0,0,0,0,0);
    tv[6]  = mk(0,1,4,1,4'b0100,12'h100,0, 4'b0000,0,0,0,0,0);
    tv[7]  = mk(0,0,0,0,4'b0100,12'h100,0, 4'b0100,1,0,0,0,0);
    tv[8]  = mk(0,0,0,0,4'b0000,12'h000,0, 4'b0000,0,0,0,0,0);
    tv[9]  = mk(0,0,0,0,4'b0100,12'h100,0, 4'b0000,0,0,0,0,0);
    tv[10] = mk(1,0,0,0,4'b0000,12'h000,0, 4'b0000,0,0,0,0,0);
    tv[11] = mk(0,1,0,0,4'b0000,12'h000,0, 4'b0000,0,0,0,0,0);
    tv[12] = mk(0,1,1,0,4'b0000,12'h000,0, 4'b0000,0,0,0,0,0);
    tv[13] = mk(0,1,2,0,4'b0000,12'h000,0, 4'b0000,0,0,0,0,0);
    tv[14] = mk(0,1,3,0,4'b0000,12'h000,0, 4'b0000,0,0,0,0,0);
    tv[15] = mk(0,0,0,0,4'b1111,12'h688,1, 4'b0001,0,0,0,0,0);
    tv[16] = mk(0,0,0,0,4'b1110,12'h688,1, 4'b0010,0,1,0,64'h14,4);
    tv[17] = mk(0,0,0,0,4'b1100,12'h688,1, 4'b0100,0,1,1,64'h15,5);
    tv[18] = mk(0,0,0,0,4'b1000,12'h688,1, 4'b1000,0,1,2,64'h16,6);
    tv[19] = mk(0,0,0,0,4'b0000,12'h688,1, 4'b0000,0,1,3,64'h17,7);
    tv[20] = mk(0,0,0,0,4'b0000,12'h000,1, 4'b0000,0,0,0,0,0);

    nxt();
    nxt();
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 21; i++) begin
      rst = tv[i].r;
      cv = tv[i].c;
      cid = tv[i].cid;
      ck = tv[i].k;
      bus.req_valid = tv[i].v;
      bus.req_id = tv[i].ids;
      bus.result_ready = tv[i].rr;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), bus.req_ready, tv[i].e_rdy);
      chk($sformatf("vec%0d_drop", i), drop, tv[i].e_drop);
      chk_out($sformatf("vec%0d", i), tv[i].e_val, tv[i].e_id,
              tv[i].e_data, tv[i].e_rd);
      nxt();
    end
    rst = 1'b0;
    idle();

    // Hold under backpressure; kill of the held id has no effect
    commit(3'd1, 1'b0);
    @(negedge clk);
    nxt();
    idle();
    set_req(0, 1'b1, 3'd1);
    @(negedge clk);
    chk("hold_grant", bus.req_ready, 4'b0001);
    nxt();
    set_req(0, 1'b0, 3'd0);
    commit(3'd1, 1'b1);
    @(negedge clk);
    chk_out("hold_load", 1'b1, 3'd1, 64'h14, 5'd4);
    chk("hold_perf0", perf, 32'd0);
    nxt();
    cv = 1'b0;
    ck = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk_out($sformatf("hold%0d", k), 1'b1, 3'd1, 64'h14, 5'd4);
      chk($sformatf("hold%0d_drop", k), drop, 1'b0);
      if (k < 5) nxt();
    end
    chk("hold_perf", perf, PerfEn ? 32'd5 : 32'd0);
    nxt();
    bus.result_ready = 1'b1;
    @(negedge clk);
    chk_out("hold_deliver", 1'b1, 3'd1, 64'h14, 5'd4);
    nxt();
    bus.result_ready = 1'b0;
    set_req(0, 1'b1, 3'd1);
    @(negedge clk);
    chk_out("hold_after", 1'b0, 3'd0, 64'h0, 5'd0);
    chk("hold_clr_ready", bus.req_ready, 4'b0000);
    chk("hold_clr_drop", drop, 1'b0);
    nxt();
    idle();

    // Uncommitted request waits; commit releases it two cycles later
    bus.result_ready = 1'b1;
    set_req(3, 1'b1, 3'd6);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("wait%0d_ready", k), bus.req_ready[3], 1'b0);
      chk($sformatf("wait%0d_valid", k), bus.result_valid, 1'b0);
      nxt();
    end
    commit(3'd6, 1'b0);
    @(negedge clk);
    chk("wait_commit_ready", bus.req_ready, 4'b0000);
    nxt();
    cv = 1'b0;
    @(negedge clk);
    chk("wait_grant", bus.req_ready, 4'b1000);
    nxt();
    set_req(3, 1'b0, 3'd0);
    @(negedge clk);
    chk_out("wait_out", 1'b1, 3'd6, 64'h17, 5'd7);
    nxt();
    @(negedge clk);
    chk("wait_done", bus.result_valid, 1'b0);
    nxt();
    idle();

    // Reset while a result is held
    commit(3'd5, 1'b0);
    nxt();
    cv = 1'b0;
    set_req(0, 1'b1, 3'd5);
    nxt();
    set_req(0, 1'b0, 3'd0);
    @(negedge clk);
    chk("rst_pre_valid", bus.result_valid, 1'b1);
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk_out("rst_post", 1'b0, 3'd0, 64'h0, 5'd0);
    chk("rst_post_id", bus.result_id, 3'd0);
    chk("rst_post_data", bus.result_data, 64'h0);
    chk("rst_post_perf", perf, 32'd0);
    nxt();
    set_req(0, 1'b1, 3'd5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_noelig%0d", k), bus.req_ready, 4'b0000);
      nxt();
    end
    commit(3'd5, 1'b0);
    nxt();
    cv = 1'b0;
    @(negedge clk);
    chk("rst_recommit", bus.req_ready, 4'b0001);
    nxt();
    idle();

    // Randomized traffic against the model
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_com[i] = 1'b0;
      m_kil[i] = 1'b0;
    end
    m_has = 1'b0;
    m_id = '0;
    m_data = '0;
    m_rd = '0;
    m_we = 1'b0;
    m_ptr = 0;
    m_stall = '0;
    for (int u = 0; u < N; u++) rv[u] = 1'b0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [3:0] e_rdy;
      logic [3:0] e_drp;
      logic [2:0] cand;
      bit ok, found, rr, hs, ld;
      int win;

      for (int u = 0; u < N; u++) begin
        if (!rv[u] && $urandom_range(0, 9) < 4) begin
          cand = 3'($urandom);
          ok = 1'b1;
          for (int w = 0; w < N; w++)
            if (w != u && rv[w] && rid[w] == cand) ok = 1'b0;
          if (ok) begin
            rv[u] = 1'b1;
            rid[u] = cand;
            rdat[u] = {$urandom, $urandom};
            rrd[u] = 5'($urandom);
            rwe[u] = 1'($urandom);
          end
        end
      end
      cv = 1'($urandom);
      cid = 3'($urandom);
      ck = ($urandom_range(0, 4) == 0);
      rr = ($urandom_range(0, 9) < 7);
      bus.result_ready = rr;
      for (int u = 0; u < N; u++) begin
        bus.req_valid[u] = rv[u];
        bus.req_id[u*IW +: IW] = rid[u];
        bus.req_data[u*DW +: DW] = rdat[u];
        bus.req_rd[u*5 +: 5] = rrd[u];
        bus.req_we[u] = rwe[u];
      end
      @(negedge clk);

      e_drp = '0;
      for (int u = 0; u < N; u++)
        if (rv[u] && m_kil[rid[u]]) e_drp[u] = 1'b1;
      found = 1'b0;
      win = 0;
      for (int k = 0; k < N; k++) begin
        int g;
        g = (m_ptr + k) % N;
        if (!found && rv[g] && m_com[rid[g]] && !m_kil[rid[g]]) begin
          found = 1'b1;
          win = g;
        end
      end
      ld = found && (!m_has || rr);
      e_rdy = e_drp;
      if (ld) e_rdy[win] = 1'b1;

      chk($sformatf("rnd%0d_ready", cyc), bus.req_ready, e_rdy);
      chk($sformatf("rnd%0d_drop", cyc), drop, |e_drp);
      chk($sformatf("rnd%0d_valid", cyc), bus.result_valid, m_has);
      chk($sformatf("rnd%0d_we", cyc), bus.result_we, m_has & m_we);
      if (m_has) begin
        chk($sformatf("rnd%0d_id", cyc), bus.result_id, m_id);
        chk($sformatf("rnd%0d_data", cyc), bus.result_data, m_data);
        chk($sformatf("rnd%0d_rd", cyc), bus.result_rd, m_rd);
      end
      chk($sformatf("rnd%0d_perf", cyc), perf, m_stall);

      if (PerfEn && m_has && !rr && m_stall != 32'hFFFF_FFFF)
        m_stall = m_stall + 1;
      hs = m_has && rr;
      if (hs) begin
        m_com[m_id] = 1'b0;
        m_kil[m_id] = 1'b0;
      end
      for (int u = 0; u < N; u++) begin
        if (e_drp[u]) begin
          m_com[rid[u]] = 1'b0;
          m_kil[rid[u]] = 1'b0;
        end
      end
      if (cv) begin
        if (ck) m_kil[cid] = 1'b1;
        else    m_com[cid] = 1'b1;
      end
      if (ld) begin
        m_has = 1'b1;
        m_id = rid[win];
        m_data = rdat[win];
        m_rd = rrd[win];
        m_we = rwe[win];
        m_ptr = (win + 1) % N;
      end else if (hs) begin
        m_has = 1'b0;
      end
      for (int u = 0; u < N; u++)
        if (e_rdy[u]) rv[u] = 1'b0;
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cvxif_result_arbiter.md
Name: cvxif_result_arbiter

Overview:
- Shares the single CV-X-IF result channel of the example coprocessor between NumReq internal execution units.
- Holds each unit's finished result until the core has committed its instruction id.
- Discards results whose id was killed.
- Selects among eligible units round-robin and drives one registered result towards the core with a valid/ready handshake.

Parameters:
- NumReq, 4, number of execution units (requesters); at least 2.
- IdWidth, 3, width of instruction id; scoreboard holds 2**IdWidth entries.
- DataWidth, 64, result data width (XLEN).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: synchronous, active-high.
- req_valid_i  in  NumReq  unit i holds a finished result.
- req_ready_o  out  NumReq  unit i's result consumed (granted or dropped) this cycle.
- req_id_i  in  NumReq*IdWidth  instruction id per unit.
- req_data_i  in  NumReq*DataWidth  result data per unit.
- req_rd_i  in  NumReq*5  destination register per unit.
- req_we_i  in  NumReq  writeback flag per unit.
- commit_valid_i  in  1  commit message valid.
- commit_id_i  in  IdWidth  committed/killed id.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- result_valid_o  out  1  result towards core valid.
- result_ready_i  in  1  core accepts result.
- result_id_o  out  IdWidth  result id.
- result_data_o  out  DataWidth  result data.
- result_rd_o  out  5  destination register.
- result_we_o  out  1  writeback enable; 0 whenever result_valid_o=0.
- drop_o  out  1  pulse: at least one killed result discarded this cycle.
- perf_stall_o  out  32  backpressure cycle count (optional feature).

Behaviour:
- Scoreboard: per id, registered bits committed and killed.
  - commit_valid_i with kill=0 sets committed[id].
  - commit_valid_i with kill=1 sets killed[id].
  - Both bits are cleared when the id's result leaves the block (handshake or drop).
  - Set takes priority over a same-cycle clear of the same id (id reuse).
- Scoreboard updates are visible the cycle after commit_valid_i. No same-cycle bypass.
- Eligibility: unit i is eligible when req_valid_i[i]=1, committed[id]=1 and killed[id]=0.
- Drop: unit i with req_valid_i[i]=1 and killed[id]=1 is dropped.
  - req_ready_o[i]=1 the same cycle; entry cleared; drop_o=1.
  - Any number of units may be dropped in one cycle; drops never wait for the output register.
- Output register: single entry. Load is allowed when the register is empty, or when result_valid_o and result_ready_i are both 1 in the same cycle (back-to-back throughput of 1/cycle).
- On load:
  - The winner gets req_ready_o=1 in the same cycle.
  - The output fields are registered.
  - result_valid_o=1 from the next cycle.
  - Latency from eligibility to result_valid_o is 1 cycle.
- Hold: while result_valid_o=1 and result_ready_i=0, all result_* outputs stay stable.
- Handshake (result_valid_o=1 and result_ready_i=1) clears the scoreboard entry of result_id_o.
- Round-robin: pointer p, reset 0.
  - Search order is p, p+1, ... mod NumReq.
  - After a grant to unit g, p becomes (g+1) mod NumReq.
  - Drops do not move p.
- Requesters must hold req_* stable until req_ready_o. Two valid requesters with the same id is illegal (assertion).
- A kill arriving for an id already in the output register has no effect on that result; it is delivered normally.
- Reset values:
  - result_valid_o=0, result_we_o=0, result_id_o=0, result_data_o=0, result_rd_o=0.
  - req_ready_o=0, drop_o=0, perf_stall_o=0.
  - Scoreboard cleared, p=0.
  - Reset mid-transfer discards the held result and all scoreboard state.

Optional Feature:
- CVXIF_ARB_PERF_EN defined: perf_stall_o increments each cycle with result_valid_o=1 and result_ready_i=0. It saturates at 32'hFFFF_FFFF and clears only on reset.
- Not defined: perf_stall_o is tied to 0 and no counter is instantiated.

Test Plan:
- Commit id 2 (kill=0), one cycle later unit 1 valid id 2, data 64'h15, rd 5, we 1 -> req_ready_o[1]=1 that cycle; next cycle result_valid_o=1, id 2, data 64'h15, rd 5, we 1.
- Units 0..3 valid with ids 0..3, all committed, result_ready_i=1 -> grants in order 0,1,2,3 on consecutive cycles; result_valid_o high 4 cycles back-to-back.
- Unit 2 valid with id 4, then kill id 4 -> next cycle req_ready_o[2]=1 and drop_o=1; result_valid_o stays 0; entry 4 cleared.
- Result for id 1 held with result_ready_i=0 for 5 cycles -> outputs stable; with CVXIF_ARB_PERF_EN, perf_stall_o=5, otherwise 0.
- Unit 3 valid with id 6 but no commit for 10 cycles -> req_ready_o[3]=0 and result_valid_o=0 throughout; commit id 6 -> result_valid_o two cycles later.
- Assert rst_i while result_valid_o=1 -> next cycle result_valid_o=0, scoreboard empty; a previously committed id is no longer eligible until re-committed.
